eth_tx_sched: RTL
=================

Name: eth_tx_sched

Overview:
- Packet scheduler in front of eth_tx; shares the single RMII transmit path between pNUM_SRC byte-stream requesters.
- Arbitrates round-robin on packet boundaries and streams the granted source's payload into eth_tx (Eth_Byte/Eth_Byte_Valid).
- Zero-pads to the minimum payload and truncates oversize payloads, then pulses Eth_Pkt_Rdy.
- Watches Tx_En to detect frame completion and enforces the inter-packet gap before the next grant.

Parameters:
- pNUM_SRC, 2, number of requesters (2..4).
- pMIN_PAYLOAD, 46, minimum payload bytes; shorter packets are zero-padded.
- pMAX_PAYLOAD, 1500, maximum payload bytes; must be ≤ eth_tx payload FIFO depth.
- pIPG_CYCLES, 48, idle Clk cycles after Tx_En falls (96 bit times at 2 bits/cycle).
- pTX_TIMEOUT, 4096, cycles to wait for Tx_En to rise, and separately to fall, before aborting.

Ports:
- Clk  in  1  RMII reference clock (50 MHz), same clock as eth_tx.
- Rst  in  1  asynchronous, active-high reset.
- Src_Data  in  8*pNUM_SRC  payload byte per source; source i occupies [8i+7:8i].
- Src_Valid  in  pNUM_SRC  byte valid per source; level high means the source requests a packet.
- Src_Last  in  pNUM_SRC  marks the final payload byte; qualified by Src_Valid.
- Src_Ready  out  pNUM_SRC  byte accepted when Src_Valid & Src_Ready; at most one bit set.
- Grant  out  pNUM_SRC  one-hot owner of the current packet; 0 in IDLE.
- Eth_Byte  out  8  to eth_tx FIFO write data.
- Eth_Byte_Valid  out  1  to eth_tx FIFO write enable.
- Eth_Pkt_Rdy  out  1  one-cycle pulse; starts frame transmission in eth_tx.
- Tx_En  in  1  from eth_tx; high while a frame is on the wire.
- Busy  out  1  high in every state except IDLE.
- Err_Oversize  out  1  one-cycle pulse when a packet is truncated.
- Err_Timeout  out  1  one-cycle pulse when a Tx_En timeout fires.

Behaviour:
- Reset: async, all outputs 0, state IDLE, byte count 0, last-grant pointer = pNUM_SRC-1 so source 0 wins first. Reset mid-packet aborts immediately; no Eth_Pkt_Rdy is issued.
- Outputs Eth_Byte, Eth_Byte_Valid, Eth_Pkt_Rdy, Err_* and Grant are registered. Src_Ready is combinational from state and Grant.
- IDLE: if any Src_Valid is set, pick the first requester after the last-grant pointer (modulo pNUM_SRC) and register Grant. Next state LOAD. Count ← 0.
- LOAD:
  - Src_Ready[g] = 1.
  - Each accepted byte appears on Eth_Byte with Eth_Byte_Valid = 1 exactly 1 cycle later; count += 1.
  - Accepted byte with Src_Last: if count_after < pMIN_PAYLOAD, go to PAD, else go to START.
  - Accepted byte without Src_Last that makes count_after == pMAX_PAYLOAD: go to DRAIN.
  - Src_Valid low: wait; no timeout.
- DRAIN: Src_Ready[g] = 1; accepted bytes are discarded with no FIFO write. On an accepted Src_Last, pulse Err_Oversize and go to START.
- PAD: Src_Ready = 0; write 0x00 each cycle until count == pMIN_PAYLOAD, then go to START.
- START: Eth_Pkt_Rdy = 1 for one cycle. Its rising edge is ≥1 cycle after the final Eth_Byte_Valid. Next state WAIT_RISE.
- WAIT_RISE: wait for Tx_En = 1, then go to WAIT_FALL. If pTX_TIMEOUT cycles elapse, pulse Err_Timeout and go to IPG.
- WAIT_FALL: wait for Tx_En = 0, then go to IPG. The same timeout rule applies.
- IPG: count pIPG_CYCLES cycles, then go to IDLE. Last-grant pointer ← g; Grant ← 0.
- Src_Valid seen outside IDLE is ignored for arbitration; a requester holding valid through IPG is granted on the first IDLE cycle.
- Eth_Byte_Valid never asserts outside LOAD/PAD plus the 1-cycle output delay; no FIFO writes occur from START to IDLE.
- Count is $clog2(pMAX_PAYLOAD+1) bits and saturates at pMAX_PAYLOAD.
- Packet length as seen by eth_tx = max(pMIN_PAYLOAD, min(src_len, pMAX_PAYLOAD)).

Test Plan:
- Single packet, src0 sends 60 bytes 0x00..0x3B → 60 FIFO writes in order, each 1 cycle after acceptance. One Eth_Pkt_Rdy pulse. Tx_En modelled high 800 cycles → Busy falls exactly 48 cycles after Tx_En falls.
- Short packet, src1 sends 10 bytes → 10 data writes + 36 writes of 0x00 (46 total), then Eth_Pkt_Rdy.
- Oversize, src0 sends 1600 bytes → exactly 1500 writes, 100 bytes accepted and dropped, one Err_Oversize pulse on the last byte, then Eth_Pkt_Rdy.
- Contention, src0 and src1 both valid continuously for 4 packets → Grant sequence 0,1,0,1. No Src_Ready asserted during IPG.
- Timeout, Tx_En held 0 after Eth_Pkt_Rdy → Err_Timeout 4096 cycles later, then IPG of 48 cycles, then IDLE.
- Reset asserted mid-LOAD at byte 20 → all outputs 0 asynchronously, no Eth_Pkt_Rdy. After release, src0 is granted first.

Source files
------------

// File: rtl/eth_tx_sched.sv
// Round-robin packet scheduler feeding eth_tx: streams one source's payload into
// the tx FIFO, pads/truncates to legal length, then waits out the frame and IPG.

module eth_tx_sched_lane (
  input  logic       xfer_i,
  input  logic       grant_i,
  input  logic       valid_i,
  input  logic       last_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       acc_o,
  output logic       last_o,
  output logic [7:0] data_o
);
  assign ready_o = xfer_i & grant_i;
  assign acc_o   = ready_o & valid_i;
  assign last_o  = acc_o & last_i;
  assign data_o  = acc_o ? data_i : 8'h00;
endmodule

module eth_tx_sched #(
  parameter int pNUM_SRC     = 2,
  parameter int pMIN_PAYLOAD = 46,
  parameter int pMAX_PAYLOAD = 1500,
  parameter int pIPG_CYCLES  = 48,
  parameter int pTX_TIMEOUT  = 4096
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [8*pNUM_SRC-1:0] Src_Data,
  input  logic [pNUM_SRC-1:0]   Src_Valid,
  input  logic [pNUM_SRC-1:0]   Src_Last,
  output logic [pNUM_SRC-1:0]   Src_Ready,
  output logic [pNUM_SRC-1:0]   Grant,
  output logic [7:0]            Eth_Byte,
  output logic                  Eth_Byte_Valid,
  output logic                  Eth_Pkt_Rdy,
  input  logic                  Tx_En,
  output logic                  Busy,
  output logic                  Err_Oversize,
  output logic                  Err_Timeout
);
  localparam int CW = $clog2(pMAX_PAYLOAD + 1);
  localparam int TW = $clog2(pTX_TIMEOUT + 1);
  localparam int IW = (pNUM_SRC > 1) ? $clog2(pNUM_SRC) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, PAD, START, WAIT_RISE, WAIT_FALL, IPG} state_t;

  state_t               state_q, state_d;
  logic [pNUM_SRC-1:0]  grant_q, grant_d;
  logic [IW-1:0]        last_q, last_d;
  logic [CW-1:0]        cnt_q, cnt_d, cnt_inc;
  logic [TW-1:0]        tmr_q, tmr_d;
  logic [7:0]           byte_q, byte_d;
  logic                 vld_q, vld_d, rdy_q, rdy_d, ovr_q, ovr_d, to_q, to_d;

  logic                         xfer, acc, last_acc, found;
  logic [pNUM_SRC-1:0]          lane_acc, lane_last;
  logic [pNUM_SRC-1:0][7:0]     lane_data;
  logic [7:0]                   sel_data;

  assign xfer = (state_q == LOAD) || (state_q == DRAIN);

  for (genvar i = 0; i < pNUM_SRC; i++) begin : g_lane
    eth_tx_sched_lane u_lane (
      .xfer_i  (xfer),
      .grant_i (grant_q[i]),
      .valid_i (Src_Valid[i]),
      .last_i  (Src_Last[i]),
      .data_i  (Src_Data[8*i +: 8]),
      .ready_o (Src_Ready[i]),
      .acc_o   (lane_acc[i]),
      .last_o  (lane_last[i]),
      .data_o  (lane_data[i])
    );
  end

  always_comb begin
    sel_data = 8'h00;
    for (int i = 0; i < pNUM_SRC; i++) sel_data = sel_data | lane_data[i];
  end

  assign acc      = |lane_acc;
  assign last_acc = |lane_last;
  assign cnt_inc  = (cnt_q == CW'(pMAX_PAYLOAD)) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    byte_d  = 8'h00;
    vld_d   = 1'b0;
    rdy_d   = 1'b0;
    ovr_d   = 1'b0;
    to_d    = 1'b0;
    found   = 1'b0;
    case (state_q)
      IDLE: if (|Src_Valid) begin
        // scan starts one past the previous owner so every requester gets a turn
        grant_d = '0;
        for (int k = 1; k <= pNUM_SRC; k++)
          for (int i = 0; i < pNUM_SRC; i++)
            if (!found && Src_Valid[i] && (i == (int'(last_q) + k) % pNUM_SRC)) begin
              grant_d[i] = 1'b1;
              found      = 1'b1;
            end
        cnt_d   = '0;
        state_d = LOAD;
      end
      LOAD: if (acc) begin
        byte_d = sel_data;
        vld_d  = 1'b1;
        cnt_d  = cnt_inc;
        if (last_acc)
          state_d = (cnt_inc < CW'(pMIN_PAYLOAD)) ? PAD : START;
        else if (cnt_inc == CW'(pMAX_PAYLOAD))
          state_d = DRAIN;
      end
      DRAIN: if (last_acc) begin
        ovr_d   = 1'b1;
        state_d = START;
      end
      PAD: begin
        vld_d = 1'b1;
        cnt_d = cnt_inc;
        if (cnt_inc >= CW'(pMIN_PAYLOAD)) state_d = START;
      end
      START: begin
        rdy_d   = 1'b1;
        tmr_d   = '0;
        state_d = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (Tx_En) begin
          tmr_d   = '0;
          state_d = WAIT_FALL;
        end else if (tmr_q == TW'(pTX_TIMEOUT - 1)) begin
          to_d    = 1'b1;
          tmr_d   = '0;
          state_d = IPG;
        end else tmr_d = tmr_q + TW'(1);
      end
      WAIT_FALL: begin
        // the cycle that sees Tx_En low is the first gap cycle
        if (!Tx_En) begin
          tmr_d   = TW'(1);
          state_d = IPG;
        end else if (tmr_q == TW'(pTX_TIMEOUT - 1)) begin
          to_d    = 1'b1;
          tmr_d   = '0;
          state_d = IPG;
        end else tmr_d = tmr_q + TW'(1);
      end
      IPG: begin
        if (tmr_q >= TW'(pIPG_CYCLES - 1)) begin
          for (int i = 0; i < pNUM_SRC; i++)
            if (grant_q[i]) last_d = IW'(i);
          grant_d = '0;
          state_d = IDLE;
        end else tmr_d = tmr_q + TW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(pNUM_SRC - 1);
      cnt_q   <= '0;
      tmr_q   <= '0;
      byte_q  <= 8'h00;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b0;
      ovr_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      byte_q  <= byte_d;
      vld_q   <= vld_d;
      rdy_q   <= rdy_d;
      ovr_q   <= ovr_d;
      to_q    <= to_d;
    end
  end

  assign Grant          = grant_q;
  assign Eth_Byte       = byte_q;
  assign Eth_Byte_Valid = vld_q;
  assign Eth_Pkt_Rdy    = rdy_q;
  assign Err_Oversize   = ovr_q;
  assign Err_Timeout    = to_q;
  assign Busy           = (state_q != IDLE);
endmodule
